cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Instruction-decode and control FSM for the 16-bit CPU.
- Sits directly upstream of the datapath. It takes the latched instruction register IR and drives every datapath control input each cycle: register-file addressing, A/B/C/status loads, muxes, ALU op, memory select/write, IR load and PC update/branch controls.
- Sequences fetch, PC increment, decode and multi-cycle execute for MOV, ALU, LDR/STR, branch, BL/BX/BLX and HALT.

Parameters:
- RLINK, 7: register index written with the return address by BL/BLX.
- MEM_WAIT, 1: cycles the FSM holds the address stable before a RAM read is consumed (1..3). Applies to fetch and LDR.

Ports:
- clk, input, 1: system clock; all state changes on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- IR, input, 16: instruction register from the datapath.
- dp_reset, output, 1: drives the datapath PC-clear input.
- writenum, output, 3: register-file write index.
- write, output, 1: register-file write enable.
- readnum, output, 3: register-file read index.
- loada, loadb, loadc, loads, output, 1 each: datapath register loads.
- vsel, output, 4: one-hot write-back select. 0001=C, 0010=PC, 0100=sximm8, 1000=mdata.
- asel, bsel, output, 1 each: ALU operand selects (asel=1 forces A to 0; bsel=1 selects sximm5).
- shift, output, 2: shifter op.
- ALUop, output, 2: ALU op.
- msel, output, 1: 0 = PC address, 1 = C address.
- mwrite, output, 1: RAM write enable.
- loadir, output, 1: IR load enable.
- sximm5, output, 16: sign-extended IR[4:0].
- sximm8, output, 16: sign-extended IR[7:0].
- tsel, output, 1: branch target select; 1 = PC+sximm8, 0 = A.
- incp, output, 1: PC increment.
- execb, output, 1: branch-evaluate strobe.
- cond, output, 3: branch condition to the branch unit; 000 = always.
- halted, output, 1: high while in HALT.

Behaviour:
- Decode fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
  - sximm5 and sximm8 are pure combinational sign extensions of IR.
- Outputs are a combinational function of state and IR (Moore-style). All enables not listed for a state are 0, and msel defaults to 0.
- Reset (reset=0, asynchronous): state is RST and the wait counter is 0.
  - All enables, write and mwrite drop immediately. dp_reset=1, halted=0, vsel=0001, indices=0.
  - An in-flight STR or register write is abandoned and never completes after release.
- RST: dp_reset=1, then IF1.
- IF1: msel=0. Stays MEM_WAIT cycles (wait counter counts up, clears on exit), then IF2.
- IF2: loadir=1, then UPD.
- UPD: incp=1, then DEC.
- DEC: dispatch; no enables asserted.
- Dispatch on opcode/op:
  - 110/10 MOV imm: MOVI (writenum=Rn, vsel=0100, write) -> IF1.
  - 110/00 MOV reg: GETB -> ALU with asel=1, ALUop=00 -> WB.
  - 101/xx ALU:
    - GETA (readnum=Rn, loada) -> GETB (readnum=Rm, loadb, shift=sh).
    - ALU (ALUop=op, loadc; loads=1 only when op=01 CMP).
    - ADD/AND/MVN -> WB (writenum=Rd, vsel=0001, write) -> IF1. CMP -> IF1 directly.
  - 011/00 LDR:
    - GETA -> ADDR (bsel=1, ALUop=00, loadc).
    - LD1 (msel=1) for MEM_WAIT cycles.
    - LD2 (msel=1, writenum=Rd, vsel=1000, write) -> IF1.
  - 100/00 STR:
    - GETA -> ADDR.
    - SB (readnum=Rd, loadb).
    - ST (msel=1, mwrite=1, exactly one cycle) -> IF1.
  - 001/00 B<cond>: BR (execb, tsel=1, cond=IR[10:8]) -> IF1.
    - pcrel uses the already-incremented PC.
  - 010/11 BL: BL1 (writenum=RLINK, vsel=0010, write) -> BL2 (execb, tsel=1, cond=000) -> IF1.
  - 010/00 BX: BX1 (readnum=Rd, loada) -> BX2 (execb, tsel=0, cond=000) -> IF1.
  - 010/10 BLX: BX1 -> BL1 -> BX2.
    - Rd is read before the link write, so BLX R7 jumps to the old R7.
  - 111/xx HALT: HALT state, halted=1, no enables. Exits only via reset.
  - Any other encoding goes to HALT.
- shift is 00 in every state except GETB.
- mwrite is high only in ST.
- Exactly one of write/mwrite/loadir/incp/execb may be high in any cycle.

Test Plan:
- Reset low mid-ST (mwrite=1) -> mwrite and write fall combinationally. After release: RST (dp_reset=1), then IF1; no RAM write ever lands.
- IR=16'hD405 (MOV R4,#5) -> cycle sequence RST, IF1, IF2(loadir), UPD(incp), DEC, MOVI. MOVI drives writenum=4, vsel=0100, write=1; sximm8=0005. Then IF1.
- ADD R2,R1,R0 LSL#1 (IR=16'hA148) -> GETA readnum=1; GETB readnum=0, shift=01; ALU ALUop=00, loads=0; WB writenum=2, vsel=0001.
  - Same test with CMP (op=01) -> loads=1 and no WB.
- LDR R3,[R1,#-2] (IR=16'h617E) with MEM_WAIT=2 -> ADDR bsel=1, sximm5=FFFE; LD1 held exactly 2 cycles with msel=1; LD2 writes R3 with vsel=1000.
- BEQ #-3 (IR=16'h21FD) -> single BR cycle with execb=1, tsel=1, cond=001, sximm8=FFFD, then IF1.
- BLX R7 (IR=16'h50E0), RLINK=7 -> BX1 readnum=7 loada, then BL1 writenum=7 vsel=0010, then BX2 tsel=0 execb.
  - Follow with IR=16'hE000 -> halted=1, held until reset.

Source files
------------

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//   Instruction-decode and control FSM for the 16-bit CPU. Sequences fetch,
//   PC increment, decode and the multi-cycle execute paths (MOV, ALU,
//   LDR/STR, B<cond>, BL/BX/BLX, HALT). It drives every datapath control
//   input from the current state and the latched instruction register.
//
// Parameters
//   RLINK    : register index that receives the return address (BL/BLX)
//   MEM_WAIT : cycles the RAM address is held before read data is used (1..3)
//
// Ports
//   clk, reset (async, active-low)
//   IR                        : latched instruction register
//   dp_reset                  : datapath PC clear
//   writenum, write, readnum  : register-file control
//   loada/loadb/loadc/loads   : datapath register loads
//   vsel (one-hot), asel, bsel, shift, ALUop : datapath muxes / ALU op
//   msel, mwrite, loadir      : memory address select, RAM write, IR load
//   sximm5, sximm8            : sign-extended immediates
//   tsel, incp, execb, cond   : PC update / branch controls
//   halted                    : high while in HALT
// -----------------------------------------------------------------------------
module cpu_controller #(
  parameter int RLINK    = 7,
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  output logic        dp_reset,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [2:0]  readnum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic [3:0]  vsel,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        msel,
  output logic        mwrite,
  output logic        loadir,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        tsel,
  output logic        incp,
  output logic        execb,
  output logic [2:0]  cond,
  output logic        halted
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPD, S_DEC,
    S_MOVI, S_GETA, S_GETB, S_ALU, S_WB,
    S_ADDR, S_LD1, S_LD2, S_SB, S_ST,
    S_BR, S_BL1, S_BL2, S_BX1, S_BX2, S_HALT
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT - 1);
  localparam logic [2:0] LINK_REG  = 3'(RLINK);

  state_t     state_reg;
  logic [1:0] wait_cnt_reg;

  // Instruction fields
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;

  assign opcode = IR[15:13];
  assign op     = IR[12:11];
  assign rn     = IR[10:8];
  assign rd     = IR[7:5];
  assign sh     = IR[4:3];
  assign rm     = IR[2:0];

  assign sximm5 = {{11{IR[4]}}, IR[4:0]};
  assign sximm8 = {{8{IR[7]}}, IR[7:0]};

  // State register and next-state logic. The shared execute states (GETA,
  // ADDR, BL1, BX1, ALU) pick their successor from IR, which is stable for
  // the whole execute phase since it only loads in IF2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_RST;
      wait_cnt_reg <= 2'd0;
    end else begin
      case (state_reg)
        S_RST: state_reg <= S_IF1;
        S_IF1: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            wait_cnt_reg <= 2'd0;
            state_reg    <= S_IF2;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 2'd1;
          end
        end
        S_IF2: state_reg <= S_UPD;
        S_UPD: state_reg <= S_DEC;
        S_DEC: begin
          casez ({opcode, op})
            5'b110_10: state_reg <= S_MOVI;
            5'b110_00: state_reg <= S_GETB;
            5'b101_??: state_reg <= S_GETA;
            5'b011_00: state_reg <= S_GETA;
            5'b100_00: state_reg <= S_GETA;
            5'b001_00: state_reg <= S_BR;
            5'b010_11: state_reg <= S_BL1;
            5'b010_00: state_reg <= S_BX1;
            5'b010_10: state_reg <= S_BX1;
            default:   state_reg <= S_HALT;  // HALT and undefined encodings
          endcase
        end
        S_MOVI: state_reg <= S_IF1;
        S_GETA: state_reg <= (opcode == 3'b101) ? S_GETB : S_ADDR;
        S_GETB: state_reg <= S_ALU;
        // CMP only updates status, so it skips write-back
        S_ALU:  state_reg <= (opcode == 3'b101 && op == 2'b01) ? S_IF1 : S_WB;
        S_WB:   state_reg <= S_IF1;
        S_ADDR: state_reg <= (opcode == 3'b011) ? S_LD1 : S_SB;
        S_LD1: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            wait_cnt_reg <= 2'd0;
            state_reg    <= S_LD2;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 2'd1;
          end
        end
        S_LD2:  state_reg <= S_IF1;
        S_SB:   state_reg <= S_ST;
        S_ST:   state_reg <= S_IF1;
        S_BR:   state_reg <= S_IF1;
        // BLX runs BX1 -> BL1 -> BX2 so the target is read before the link write
        S_BL1:  state_reg <= (op == 2'b10) ? S_BX2 : S_BL2;
        S_BL2:  state_reg <= S_IF1;
        S_BX1:  state_reg <= (op == 2'b10) ? S_BL1 : S_BX2;
        S_BX2:  state_reg <= S_IF1;
        S_HALT: state_reg <= S_HALT;
        default: state_reg <= S_RST;
      endcase
    end
  end

  // Control outputs: a pure function of state (and IR fields).
  always_comb begin
    dp_reset = 1'b0;
    writenum = 3'd0;
    write    = 1'b0;
    readnum  = 3'd0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    vsel     = 4'b0001;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    msel     = 1'b0;
    mwrite   = 1'b0;
    loadir   = 1'b0;
    tsel     = 1'b0;
    incp     = 1'b0;
    execb    = 1'b0;
    cond     = 3'b000;
    halted   = 1'b0;
    case (state_reg)
      S_RST:  dp_reset = 1'b1;
      S_IF2:  loadir   = 1'b1;
      S_UPD:  incp     = 1'b1;
      S_MOVI: begin
        writenum = rn;
        vsel     = 4'b0100;
        write    = 1'b1;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
        shift   = sh;
      end
      S_ALU: begin
        loadc = 1'b1;
        if (opcode == 3'b101) begin
          ALUop = op;
          loads = (op == 2'b01);
        end else begin
          asel  = 1'b1;  // MOV reg: 0 + shifted B
        end
      end
      S_WB: begin
        writenum = rd;
        write    = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LD1:  msel = 1'b1;
      S_LD2: begin
        msel     = 1'b1;
        writenum = rd;
        vsel     = 4'b1000;
        write    = 1'b1;
      end
      S_SB: begin
        readnum = rd;
        loadb   = 1'b1;
      end
      S_ST: begin
        msel   = 1'b1;
        mwrite = 1'b1;
      end
      S_BR: begin
        execb = 1'b1;
        tsel  = 1'b1;
        cond  = rn;
      end
      S_BL1: begin
        writenum = LINK_REG;
        vsel     = 4'b0010;
        write    = 1'b1;
      end
      S_BL2: begin
        execb = 1'b1;
        tsel  = 1'b1;
      end
      S_BX1: begin
        readnum = rd;
        loada   = 1'b1;
      end
      S_BX2:  execb  = 1'b1;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
//   Drives instruction words into cpu_controller (MEM_WAIT=2, RLINK=7) and
//   compares the full control vector each cycle against an expected-state
//   queue filled when each instruction is presented.
// -----------------------------------------------------------------------------
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IR;
  logic        dp_reset, write, loada, loadb, loadc, loads, asel, bsel;
  logic        msel, mwrite, loadir, tsel, incp, execb, halted;
  logic [2:0]  writenum, readnum, cond;
  logic [3:0]  vsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm5, sximm8;

  cpu_controller #(.RLINK(7), .MEM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .IR(IR),
    .dp_reset(dp_reset), .writenum(writenum), .write(write), .readnum(readnum),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .vsel(vsel), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .msel(msel), .mwrite(mwrite), .loadir(loadir),
    .sximm5(sximm5), .sximm8(sximm8),
    .tsel(tsel), .incp(incp), .execb(execb), .cond(cond), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dp_reset;
    logic [2:0] writenum;
    logic       write;
    logic [2:0] readnum;
    logic       loada, loadb, loadc, loads;
    logic [3:0] vsel;
    logic       asel, bsel;
    logic [1:0] shift, alu_op;
    logic       msel, mwrite, loadir, tsel, incp, execb;
    logic [2:0] cond;
    logic       halted;
  } ctl_t;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  logic [31:0] act_vec;
  assign act_vec = {dp_reset, writenum, write, readnum, loada, loadb, loadc,
                    loads, vsel, asel, bsel, shift, ALUop, msel, mwrite,
                    loadir, tsel, incp, execb, cond, halted};

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expected per-state control vectors
  function automatic ctl_t s_base();
    ctl_t c = '0;
    c.vsel = 4'b0001;
    return c;
  endfunction
  function automatic ctl_t s_rst();
    ctl_t c = s_base(); c.dp_reset = 1'b1; return c;
  endfunction
  function automatic ctl_t s_if2();
    ctl_t c = s_base(); c.loadir = 1'b1; return c;
  endfunction
  function automatic ctl_t s_upd();
    ctl_t c = s_base(); c.incp = 1'b1; return c;
  endfunction
  function automatic ctl_t s_movi(input logic [2:0] r);
    ctl_t c = s_base(); c.writenum = r; c.vsel = 4'b0100; c.write = 1'b1; return c;
  endfunction
  function automatic ctl_t s_geta(input logic [2:0] r);
    ctl_t c = s_base(); c.readnum = r; c.loada = 1'b1; return c;
  endfunction
  function automatic ctl_t s_getb(input logic [2:0] r, input logic [1:0] s);
    ctl_t c = s_base(); c.readnum = r; c.loadb = 1'b1; c.shift = s; return c;
  endfunction
  function automatic ctl_t s_alu(input logic [1:0] o, input logic a, input logic st);
    ctl_t c = s_base(); c.loadc = 1'b1; c.alu_op = o; c.asel = a; c.loads = st; return c;
  endfunction
  function automatic ctl_t s_wb(input logic [2:0] r);
    ctl_t c = s_base(); c.writenum = r; c.write = 1'b1; return c;
  endfunction
  function automatic ctl_t s_addr();
    ctl_t c = s_base(); c.bsel = 1'b1; c.loadc = 1'b1; return c;
  endfunction
  function automatic ctl_t s_ld1();
    ctl_t c = s_base(); c.msel = 1'b1; return c;
  endfunction
  function automatic ctl_t s_ld2(input logic [2:0] r);
    ctl_t c = s_base(); c.msel = 1'b1; c.writenum = r; c.vsel = 4'b1000;
    c.write = 1'b1; return c;
  endfunction
  function automatic ctl_t s_st();
    ctl_t c = s_base(); c.msel = 1'b1; c.mwrite = 1'b1; return c;
  endfunction
  function automatic ctl_t s_br(input logic [2:0] cc, input logic t);
    ctl_t c = s_base(); c.execb = 1'b1; c.tsel = t; c.cond = cc; return c;
  endfunction
  function automatic ctl_t s_bl1();
    ctl_t c = s_base(); c.writenum = 3'd7; c.vsel = 4'b0010; c.write = 1'b1; return c;
  endfunction
  function automatic ctl_t s_halt();
    ctl_t c = s_base(); c.halted = 1'b1; return c;
  endfunction

  task automatic push(input string tag, input ctl_t c);
    exp_t e;
    e.tag = tag;
    e.v   = c;
    sb_q.push_back(e);
  endtask

  // Compare one queued state per cycle, sampling on the falling edge.
  task automatic drain(input string name);
    exp_t e;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      check({name, ".", e.tag}, act_vec, e.v);
      @(posedge clk);
      #1;
    end
    $display("txn %-8s checks=%0d fails=%0d", name, n_checks, n_fail);
  endtask

  // Presents a new instruction; expects the two-cycle fetch, IR load,
  // PC increment and decode.
  task automatic fetch(input logic [15:0] ir);
    IR = ir;
    push("IF1a", s_base());
    push("IF1b", s_base());
    push("IF2", s_if2());
    push("UPD", s_upd());
    push("DEC", s_base());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    push("RST_LOW", s_rst());
    drain("reset");
    reset = 1'b1;
    push("RST_REL", s_rst());
    drain("release");
  endtask

  initial begin
    reset = 1'b0;
    IR    = 16'h0000;
    @(posedge clk);
    #1;
    do_reset();

    // MOV R4,#5
    fetch(16'hD405);
    push("MOVI", s_movi(3'd4));
    #1 check("MOV.sximm8", {16'h0, sximm8}, 32'h0000_0005);
    drain("MOVI");

    // ADD R2,R1,R0 LSL#1
    fetch(16'hA148);
    push("GETA", s_geta(3'd1));
    push("GETB", s_getb(3'd0, 2'b01));
    push("ALU", s_alu(2'b00, 1'b0, 1'b0));
    push("WB", s_wb(3'd2));
    drain("ADD");

    // CMP R1,R0 LSL#1: status load, no write-back
    fetch(16'hA948);
    push("GETA", s_geta(3'd1));
    push("GETB", s_getb(3'd0, 2'b01));
    push("ALU", s_alu(2'b01, 1'b0, 1'b1));
    drain("CMP");

    // MOV R3,R2
    fetch(16'hC062);
    push("GETB", s_getb(3'd2, 2'b00));
    push("ALU", s_alu(2'b00, 1'b1, 1'b0));
    push("WB", s_wb(3'd3));
    drain("MOVR");

    // LDR R3,[R1,#-2]: LD1 held for exactly MEM_WAIT=2 cycles
    fetch(16'h617E);
    push("GETA", s_geta(3'd1));
    push("ADDR", s_addr());
    push("LD1a", s_ld1());
    push("LD1b", s_ld1());
    push("LD2", s_ld2(3'd3));
    #1 check("LDR.sximm5", {16'h0, sximm5}, 32'h0000_FFFE);
    drain("LDR");

    // STR R2,[R1,#3]
    fetch(16'h8143);
    push("GETA", s_geta(3'd1));
    push("ADDR", s_addr());
    push("SB", s_getb(3'd2, 2'b00));
    push("ST", s_st());
    #1 check("STR.sximm5", {16'h0, sximm5}, 32'h0000_0003);
    drain("STR");

    // BEQ #-3
    fetch(16'h21FD);
    push("BR", s_br(3'b001, 1'b1));
    #1 check("BEQ.sximm8", {16'h0, sximm8}, 32'h0000_FFFD);
    drain("BEQ");

    // BL #2
    fetch(16'h5802);
    push("BL1", s_bl1());
    push("BL2", s_br(3'b000, 1'b1));
    drain("BL");

    // BX R3
    fetch(16'h4060);
    push("BX1", s_geta(3'd3));
    push("BX2", s_br(3'b000, 1'b0));
    drain("BX");

    // BLX R7: read R7 before the link write
    fetch(16'h50E0);
    push("BX1", s_geta(3'd7));
    push("BL1", s_bl1());
    push("BX2", s_br(3'b000, 1'b0));
    drain("BLX");

    // HALT holds until reset
    fetch(16'hE000);
    for (int i = 0; i < 5; i++) push("HALT", s_halt());
    drain("HALT");
    do_reset();

    // Undefined encoding falls into HALT
    fetch(16'h0000);
    for (int i = 0; i < 3; i++) push("HALT", s_halt());
    drain("UNDEF");
    do_reset();

    // STR aborted by reset while mwrite is high
    fetch(16'h8143);
    push("GETA", s_geta(3'd1));
    push("ADDR", s_addr());
    push("SB", s_getb(3'd2, 2'b00));
    drain("STR_pre");
    @(negedge clk);
    check("ABORT.ST", act_vec, s_st());
    #1 reset = 1'b0;
    #1 check("ABORT.async", act_vec, s_rst());
    @(posedge clk);
    #1 reset = 1'b1;
    push("RST", s_rst());
    push("IF1a", s_base());
    push("IF1b", s_base());
    push("IF2", s_if2());
    drain("ABORT");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
